bit_serial_alu_seq: RTL and testbench



---
 rtl/bit_serial_alu_seq.sv | 161 ++++++++++++++++
 tb/tb_bit_serial_alu_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ADD/SUB sequencer: drives one external 1-bit ALU slice LSB first
// and returns the word result with C/Z/O/S flags through a valid/ready port.
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_c,
  output logic             rsp_z,
  output logic             rsp_o,
  output logic             rsp_s,
  output logic             busy,
  output logic             alu_op1,
  output logic             alu_op2,
  output logic             alu_opsel,
  output logic             alu_cin,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // RUN   | one operand bit per clock through the slice
  // DONE  | response held until rsp_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_c_q, rsp_c_d;
  logic             rsp_z_q, rsp_z_d;
  logic             rsp_o_q, rsp_o_d;
  logic             rsp_s_q, rsp_s_d;
  logic [WIDTH-1:0] word_final;

  // Final word includes the bit the slice is producing right now.
  assign word_final = {alu_result, res_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_sh_d     = res_sh_q;
    op_d         = op_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    rsp_result_d = rsp_result_q;
    rsp_c_d      = rsp_c_q;
    rsp_z_d      = rsp_z_q;
    rsp_o_d      = rsp_o_q;
    rsp_s_d      = rsp_s_q;
    if (abort) begin
      state_d  = IDLE;
      a_sh_d   = '0;
      b_sh_d   = '0;
      res_sh_d = '0;
      carry_d  = 1'b0;
      idx_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_sh_d   = req_a;
            b_sh_d   = req_b;
            op_d     = req_op;
            carry_d  = req_op;
            idx_d    = '0;
            res_sh_d = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          a_sh_d   = a_sh_q >> 1;
          b_sh_d   = b_sh_q >> 1;
          res_sh_d = word_final;
          carry_d  = alu_cout;
          if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            rsp_result_d = word_final;
            rsp_c_d      = alu_cout;
            rsp_o_d      = carry_q ^ alu_cout;
            rsp_z_d      = ~|word_final;
            rsp_s_d      = alu_result;
            state_d      = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      op_q         <= 1'b0;
      carry_q      <= 1'b0;
      idx_q        <= '0;
      rsp_result_q <= '0;
      rsp_c_q      <= 1'b0;
      rsp_z_q      <= 1'b0;
      rsp_o_q      <= 1'b0;
      rsp_s_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_sh_q     <= res_sh_d;
      op_q         <= op_d;
      carry_q      <= carry_d;
      idx_q        <= idx_d;
      rsp_result_q <= rsp_result_d;
      rsp_c_q      <= rsp_c_d;
      rsp_z_q      <= rsp_z_d;
      rsp_o_q      <= rsp_o_d;
      rsp_s_q      <= rsp_s_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign rsp_result = rsp_result_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_o      = rsp_o_q;
  assign rsp_s      = rsp_s_q;

  // Slice operand lines are parked low outside RUN; opsel keeps the last op.
  assign alu_op1   = (state_q == RUN) ? a_sh_q[0] : 1'b0;
  assign alu_op2   = (state_q == RUN) ? b_sh_q[0] : 1'b0;
  assign alu_cin   = (state_q == RUN) ? carry_q   : 1'b0;
  assign alu_opsel = op_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq with a behavioural 1-bit slice
// and a scoreboard of expected responses.
module tb_bit_serial_alu_seq;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic c, z, o, s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic req_op = 1'b0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic rsp_c, rsp_z, rsp_o, rsp_s, busy;
  logic alu_op1, alu_op2, alu_opsel, alu_cin, alu_result, alu_cout;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Behavioural slice
  logic b_eff;
  assign b_eff      = alu_op2 ^ alu_opsel;
  assign alu_result = alu_op1 ^ b_eff ^ alu_cin;
  assign alu_cout   = (alu_op1 & b_eff) | (alu_op1 & alu_cin) | (b_eff & alu_cin);

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_o(rsp_o), .rsp_s(rsp_s),
    .busy(busy),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opsel(alu_opsel), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    exp_t e;
    logic [W-1:0] bb;
    logic [W:0] sum;
    bb  = op ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op};
    e.r = sum[W-1:0];
    e.c = sum[W];
    e.z = (sum[W-1:0] == '0);
    e.s = sum[W-1];
    e.o = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t g;
    g.r = rsp_result; g.c = rsp_c; g.z = rsp_z; g.o = rsp_o; g.s = rsp_s;
    return g;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input exp_t e, input int hold, input bit noise, input string name);
    exp_t want, got;
    int cnt;
    sb.push_back(e);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    @(posedge clk); #1;
    if (noise) begin
      req_a = ~a; req_b = ~b; req_op = ~op;
    end else begin
      req_valid = 1'b0; req_a = W'($urandom); req_b = W'($urandom); req_op = 1'($urandom);
    end
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < 20) begin
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL %s run_status: req_ready=%b busy=%b want 0/1", name, req_ready, busy);
      end
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != W) begin
      errors++; $display("FAIL %s latency: got %0d cycles want %0d", name, cnt, W);
    end
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s scoreboard_empty", name);
      want = e;
    end else begin
      want = sb.pop_front();
    end
    got = observed();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s result: got r=%h c%b z%b o%b s%b want r=%h c%b z%b o%b s%b",
               name, got.r, got.c, got.z, got.o, got.s, want.r, want.c, want.z, want.o, want.s);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      got = observed();
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || got !== want) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b ready=%b r=%h want valid=1 ready=0 r=%h",
                 name, i, rsp_valid, req_ready, got.r, want.r);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    got = observed();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || got !== want) begin
      errors++;
      $display("FAIL %s post_handshake: valid=%b ready=%b busy=%b r=%h want 0/1/0 r=%h",
               name, rsp_valid, req_ready, busy, got.r, want.r);
    end
    checks++;
    if (alu_opsel !== op || alu_op1 !== 1'b0 || alu_op2 !== 1'b0 || alu_cin !== 1'b0) begin
      errors++;
      $display("FAIL %s alu_idle: opsel=%b op1=%b op2=%b cin=%b want %b/0/0/0",
               name, alu_opsel, alu_op1, alu_op2, alu_cin, op);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_result !== '0 ||
        {rsp_c, rsp_z, rsp_o, rsp_s} !== 4'b0 ||
        {alu_op1, alu_op2, alu_opsel, alu_cin} !== 4'b0) begin
      errors++;
      $display("FAIL %s: rdy=%b vld=%b busy=%b r=%h flags=%b alu=%b want 1/0/0/00/0000/0000",
               name, req_ready, rsp_valid, busy, rsp_result, {rsp_c, rsp_z, rsp_o, rsp_s},
               {alu_op1, alu_op2, alu_opsel, alu_cin});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    run_op(8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1}, 0, 0, "add_7f_01");
    run_op(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, 0, 0, "add_ff_01");
    run_op(8'h05, 8'h05, 1'b1, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, 0, 0, "sub_05_05");
    run_op(8'h80, 8'h01, 1'b1, '{8'h7F, 1'b1, 1'b0, 1'b1, 1'b0}, 0, 0, "sub_80_01");
    run_op(8'h00, 8'h01, 1'b1, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}, 0, 0, "sub_00_01");
  endtask

  task automatic test_hold();
    run_op(8'h3C, 8'h5A, 1'b0, '{8'h96, 1'b0, 1'b0, 1'b1, 1'b1}, 5, 1, "hold_add");
  endtask

  task automatic test_abort();
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'hA5; req_b = 8'h3C; req_op = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
        {alu_op1, alu_op2, alu_cin} !== 3'b0) begin
      errors++;
      $display("FAIL abort_idle: rdy=%b busy=%b vld=%b alu=%b want 1/0/0/000",
               req_ready, busy, rsp_valid, {alu_op1, alu_op2, alu_cin});
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL abort_no_rsp: cycle %0d rsp_valid=%b want 0", i, rsp_valid);
      end
    end
    run_op(8'h01, 8'h02, 1'b0, '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0}, 0, 0, "after_abort");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'h12; req_b = 8'h34; req_op = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h20, 1'b1, '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1}, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic op;
    for (int n = 0; n < 1000; n++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 1'($urandom);
      if (n % 50 == 0) b = a;
      run_op(a, b, op, model(a, b, op), int'($urandom_range(0, 2)), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_abort();
    test_reset_mid_run();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
